// File: rtl/run_length_detector.sv
`default_nettype none
// ============================================================================
// Module   : run_length_detector
// Purpose  : Serial equal-run monitor. Samples w on edges where en=1 and
//            tracks the length of the current run of identical values.
//            z is asserted while the run length is at least RUN_LEN and the
//            run value is enabled by mode. The run value and a saturating
//            run count are also reported. Used as a line-idle / stuck-bit
//            monitor on a serial input path.
//
// Parameters
//   RUN_LEN  : qualifying run length, legal range 2 .. 2**CNT_W-1
//   CNT_W    : width of run_cnt
//
// Ports
//   clk      : in  1       rising-edge clock
//   rst_n    : in  1       synchronous reset, active-low
//   en       : in  1       sample qualifier (w consumed only when en=1)
//   w        : in  1       serial data bit
//   mode     : in  2       00 both values, 01 zeros only, 10 ones only,
//                          11 detection off (counting continues)
//   z        : out 1       registered detect flag
//   z_val    : out 1       value of the current run
//   run_cnt  : out CNT_W   current run length, saturating
//   run_hit  : out 1       one-cycle pulse on each 0->1 transition of z
//                          (only when RUN_DET_EVENT_EN is defined)
//
// Configuration macro
//   RUN_DET_EVENT_EN : adds the run_hit port and its register
//
// Revision : 1.0 - initial release
// ============================================================================
module run_length_detector #(
    parameter int RUN_LEN = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    output logic             z,
    output logic             z_val,
`ifdef RUN_DET_EVENT_EN
    output logic [CNT_W-1:0] run_cnt,
    output logic             run_hit
`else
    output logic [CNT_W-1:0] run_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_run_len = CNT_W'(RUN_LEN);

    localparam logic [1:0] c_mode_both = 2'b00;
    localparam logic [1:0] c_mode_zero = 2'b01;
    localparam logic [1:0] c_mode_one  = 2'b10;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic             r_have_prev;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_z;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic             w_have_prev_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_qual;
    logic             w_z_nxt;

    always_comb begin
        w_have_prev_nxt = r_have_prev;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        if (en) begin
            // The first sample after reset always opens a new run, so the
            // reset value of r_last never counts as a "previous" sample.
            if (!r_have_prev || (w != r_last)) begin
                w_have_prev_nxt = 1'b1;
                w_last_nxt      = w;
                w_cnt_nxt       = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_cnt != c_cnt_max) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Qualification looks at the run value that will be visible after this
    // edge, combined with the mode present now; a mode change alone is
    // therefore reflected on z at the next edge even while en=0.
    always_comb begin
        w_qual = 1'b0;
        case (mode)
            c_mode_both: w_qual = 1'b1;
            c_mode_zero: w_qual = ~w_last_nxt;
            c_mode_one:  w_qual = w_last_nxt;
            default:     w_qual = 1'b0;
        endcase
    end

    assign w_z_nxt = (w_cnt_nxt >= c_run_len) && w_qual;

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_have_prev <= 1'b0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_z         <= 1'b0;
        end else begin
            r_have_prev <= w_have_prev_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_z         <= w_z_nxt;
        end
    end

    assign z       = r_z;
    assign z_val   = r_last;
    assign run_cnt = r_cnt;

`ifdef RUN_DET_EVENT_EN
    // Rising-edge detect on z, computed from next and current z so the
    // pulse lines up with the first cycle z is high.
    logic r_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_z_nxt & ~r_z;
        end
    end

    assign run_hit = r_hit;
`endif

endmodule
`default_nettype wire
